// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: queues IF predictions with their alternate PC,
// retires them in order as EX resolves, and drives predictor update, redirect and flush.
module branch_resolve_ctrl #(
    parameter int PC_W      = 32,
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic [PC_W-1:0]              pred_alt_pc,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         upd_valid,
    output logic                         upd_taken,
    output logic                         redirect_valid,
    output logic [PC_W-1:0]              redirect_pc,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic [15:0]                  br_cnt,
    output logic [15:0]                  miss_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FC_W-1:0]   r_fcnt;
    logic [FC_W-1:0]   w_fcnt_nxt;

    logic              r_q_taken [DEPTH];
    logic [PC_W-1:0]   r_q_alt   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_upd_valid;
    logic              r_upd_taken;
    logic              r_redirect_valid;
    logic [PC_W-1:0]   r_redirect_pc;
    logic              r_flush;
    logic [15:0]       r_br_cnt;
    logic [15:0]       r_miss_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_run;
    logic              w_push;
    logic              w_pop;
    logic              w_miss;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_run   = (r_state == ST_RUN);
    assign w_push  = pred_valid && pred_ready;
    assign w_pop   = res_valid && !w_empty && w_run;
    assign w_miss  = w_pop && (res_taken != r_q_taken[r_rd_ptr]);

    // Readiness is gated by reset so every output reads 0 while reset is held.
    assign pred_ready = rst && w_run && !w_full;

    // FSM state and flush down-counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Next-state logic: a mispredict opens a flush window of FLUSH_CYC cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_RUN: begin
                if (w_miss) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = FC_W'(FLUSH_CYC - 1);
                end else begin
                    w_fcnt_nxt  = '0;
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt  = r_fcnt - FC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = '0;
            end
        endcase
    end

    // Queue payload storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push && !w_miss) begin
            r_q_taken[r_wr_ptr] <= pred_taken;
            r_q_alt[r_wr_ptr]   <= pred_alt_pc;
        end
    end

    // Queue pointers and occupancy; a mispredict empties the queue and drops any same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_miss) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered resolve responses and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_upd_valid      <= 1'b0;
            r_upd_taken      <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_br_cnt         <= 16'd0;
            r_miss_cnt       <= 16'd0;
        end else begin
            r_upd_valid      <= w_pop;
            r_upd_taken      <= w_pop && res_taken;
            r_redirect_valid <= w_miss;
            if (w_miss) begin
                r_redirect_pc <= r_q_alt[r_rd_ptr];
            end
            r_flush          <= (w_state_nxt == ST_FLUSH);
            r_br_cnt         <= r_br_cnt + {15'd0, w_pop};
            r_miss_cnt       <= r_miss_cnt + {15'd0, w_miss};
        end
    end

    assign upd_valid      = r_upd_valid;
    assign upd_taken      = r_upd_taken;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign outstanding    = r_count;
    assign br_cnt         = r_br_cnt;
    assign miss_cnt       = r_miss_cnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: a queue-based reference model predicts
// readiness, occupancy, counters and the delayed update/redirect responses.
module tb_branch_resolve_ctrl;

    localparam int PC_W      = 32;
    localparam int DEPTH     = 4;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              pred_valid;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_alt_pc;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic              upd_valid;
    logic              upd_taken;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              flush;
    logic [CNT_W-1:0]  outstanding;
    logic [15:0]       br_cnt;
    logic [15:0]       miss_cnt;

    branch_resolve_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_alt_pc(pred_alt_pc),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_taken(upd_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .outstanding(outstanding),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic taken; logic [31:0] alt; } ent_t;
    typedef struct { logic taken; logic miss; logic [31:0] pc; } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   flush_left = 0;
    int   exp_br     = 0;
    int   exp_miss   = 0;
    int   n_tests    = 0;
    int   n_fail     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every expected response is due at the negedge right after its resolve edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("upd_valid", {31'd0, upd_valid}, 32'd1);
                chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
                chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.miss});
                if (e.miss) chk("redirect_pc", redirect_pc, e.pc);
            end else begin
                chk("upd_spurious", {31'd0, upd_valid}, 32'd0);
                chk("redirect_spurious", {31'd0, redirect_valid}, 32'd0);
            end
        end
    end

    task automatic model_reset();
        mq.delete();
        sb.delete();
        flush_left = 0;
        exp_br     = 0;
        exp_miss   = 0;
    endtask

    task automatic step(input logic pv, input logic pt, input logic [31:0] alt,
                        input logic rv, input logic rt);
        logic er, push, pop, miss;
        ent_t h;
        @(negedge clk);
        #1;
        er = (flush_left == 0) && (mq.size() < DEPTH);
        chk("pred_ready", {31'd0, pred_ready}, {31'd0, er});
        chk("outstanding", {{(32-CNT_W){1'b0}}, outstanding}, mq.size());
        chk("flush", {31'd0, flush}, {31'd0, (flush_left > 0)});
        chk("br_cnt", {16'd0, br_cnt}, exp_br & 32'hFFFF);
        chk("miss_cnt", {16'd0, miss_cnt}, exp_miss & 32'hFFFF);
        pred_valid  = pv;
        pred_taken  = pt;
        pred_alt_pc = alt;
        res_valid   = rv;
        res_taken   = rt;
        push = pv && er;
        pop  = rv && (mq.size() > 0) && (flush_left == 0);
        miss = 1'b0;
        if (pop) begin
            h    = mq[0];
            miss = (rt != h.taken);
            sb.push_back('{rt, miss, h.alt});
            exp_br++;
            if (miss) exp_miss++;
        end
        if (miss) begin
            mq.delete();
            flush_left = FLUSH_CYC;
        end else begin
            if (flush_left > 0) flush_left--;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{pt, alt});
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_pred_ready", {31'd0, pred_ready}, 32'd0);
        chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_upd_taken", {31'd0, upd_taken}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_outstanding", {{(32-CNT_W){1'b0}}, outstanding}, 32'd0);
        chk("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
        chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    endtask

    task automatic idle_inputs();
        pred_valid  = 1'b0;
        pred_taken  = 1'b0;
        pred_alt_pc = 32'd0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
    endtask

    initial begin
        logic rt;
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Single correct resolve.
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,   1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0,   1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,   1'b0, 1'b0);

        // Mispredict on the oldest entry; pushes during the flush are lost.
        step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h20, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h30, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h40 + i, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Fill to DEPTH, then push while full with a correct resolve.
        step(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h5, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, mq.size() > 0 ? mq[0].taken : 1'b0);

        // Streaming push+pop with alternating directions across pointer wrap.
        step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, i[0], 32'h300 + i, 1'b1, mq[0].taken);
        step(1'b0, 1'b0, 32'h0, 1'b1, mq[0].taken);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset during the first flush cycle, then resolve on an empty queue.
        step(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b1, 1'b1);
        @(negedge clk);
        #1;
        idle_inputs();
        chk("flush_before_rst", {31'd0, flush}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic, mostly correct resolves.
        for (int i = 0; i < 400; i++) begin
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) rt = mq[0].taken;
            else rt = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                 1'($urandom_range(0, 1)), rt);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
